// File: rtl/synth_pkg.sv
// Shared definitions for the voice allocator: FSM state encoding, per-voice
// register offsets and the default spacing between voice register windows.
package synth_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALLOC,
    S_OFF_SETUP,
    S_OFF_STB,
    S_INCR_SETUP,
    S_INCR_STB,
    S_ON_SETUP,
    S_ON_STB
  } state_t;

  localparam logic [15:0] REG_GATE        = 16'd0;
  localparam logic [15:0] REG_INCR        = 16'd1;
  localparam int          DEF_CHAN_STRIDE = 8;
  localparam int          KEY_W           = 7;

  // The second cycle of every bus write, where the strobe is high.
  function automatic logic is_strobe(input state_t s);
    return (s == S_OFF_STB) || (s == S_INCR_STB) || (s == S_ON_STB);
  endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational voice search: lowest free voice, lowest busy voice holding a
// given key, and the busy voice with the largest age (ties go to lowest index).
module voice_select #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8,
  parameter int KEY_W      = 7,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_VOICES-1:0]            busy,
  input  logic [NUM_VOICES-1:0][KEY_W-1:0] keys,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0] ages,
  input  logic [KEY_W-1:0]                 key,
  output logic [IDX_W-1:0]                 free_idx,
  output logic                             free_found,
  output logic [IDX_W-1:0]                 match_idx,
  output logic                             match_found,
  output logic [IDX_W-1:0]                 oldest_idx
);

  logic [AGE_W-1:0] best_age;
  logic             best_valid;

  always_comb begin
    free_idx    = '0;
    free_found  = 1'b0;
    match_idx   = '0;
    match_found = 1'b0;
    oldest_idx  = '0;
    best_age    = '0;
    best_valid  = 1'b0;

    // Walking downwards lets the lowest qualifying index overwrite the rest.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy[i] && keys[i] == key) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
    end

    // Strict greater-than keeps the earliest (lowest) index on ties.
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (busy[i] && (!best_valid || ages[i] > best_age)) begin
        best_valid = 1'b1;
        best_age   = ages[i];
        oldest_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Note-event to voice allocator driving per-voice gate/increment registers over
// a two-cycle strobed write bus. Define VOICE_ALLOC_STEAL_EN to steal the oldest voice.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int          NUM_VOICES  = 4,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          CHAN_STRIDE = DEF_CHAN_STRIDE,
  parameter int          AGE_W       = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  EvValid,
  output logic                  EvReady,
  input  logic                  EvNoteOn,
  input  logic [KEY_W-1:0]      EvKey,
  input  logic [7:0]            EvIncr,
  output logic [15:0]           BusAddress,
  output logic [7:0]            BusData,
  output logic                  BusReadWrite,
  output logic                  BusClock,
  output logic [NUM_VOICES-1:0] VoiceBusy,
  output logic                  Dropped
);

  localparam int               IDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  state_t                           state_q, state_d;
  logic                             ev_ready_q, ev_ready_d;
  logic [KEY_W-1:0]                 key_q, key_d;
  logic                             on_q, on_d;
  logic [7:0]                       incr_q, incr_d;
  logic [IDX_W-1:0]                 v_q, v_d;
  logic [NUM_VOICES-1:0]            busy_q, busy_d;
  logic [NUM_VOICES-1:0][KEY_W-1:0] keys_q, keys_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0] ages_q, ages_d;
  logic [15:0]                      addr_q, addr_d;
  logic [7:0]                       data_q, data_d;
  logic                             bus_clk_q, bus_clk_d;
  logic                             dropped_q, dropped_d;

  logic [KEY_W-1:0] sel_key;
  logic [IDX_W-1:0] free_idx, match_idx, oldest_idx;
  logic             free_found, match_found;
  logic             age_step;
  logic [15:0]      window;

  // The search runs on the live key while idle so a drop can be flagged at acceptance.
  assign sel_key = (state_q == S_IDLE) ? EvKey : key_q;

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .KEY_W      (KEY_W),
    .IDX_W      (IDX_W)
  ) u_voice_select (
    .busy        (busy_q),
    .keys        (keys_q),
    .ages        (ages_q),
    .key         (sel_key),
    .free_idx    (free_idx),
    .free_found  (free_found),
    .match_idx   (match_idx),
    .match_found (match_found),
    .oldest_idx  (oldest_idx)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    key_d     = key_q;
    on_d      = on_q;
    incr_d    = incr_q;
    v_d       = v_q;
    busy_d    = busy_q;
    keys_d    = keys_q;
    ages_d    = ages_q;
    dropped_d = 1'b0;
    age_step  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (EvValid && ev_ready_q) begin
          key_d   = EvKey;
          on_d    = EvNoteOn;
          incr_d  = EvIncr;
          state_d = S_ALLOC;
`ifndef VOICE_ALLOC_STEAL_EN
          dropped_d = EvNoteOn && !match_found && !free_found;
`endif
        end
      end
      S_ALLOC: begin
        state_d = S_IDLE;
        if (on_q) begin
          if (match_found) begin
            v_d      = match_idx;
            state_d  = S_OFF_SETUP;
            age_step = 1'b1;
          end else if (free_found) begin
            v_d      = free_idx;
            state_d  = S_INCR_SETUP;
            age_step = 1'b1;
          end else begin
            v_d = oldest_idx;
`ifdef VOICE_ALLOC_STEAL_EN
            state_d  = S_OFF_SETUP;
            age_step = 1'b1;
`endif
          end
          if (age_step) begin
            busy_d[v_d] = 1'b1;
            keys_d[v_d] = key_q;
          end
        end else if (match_found) begin
          v_d               = match_idx;
          busy_d[match_idx] = 1'b0;
          state_d           = S_OFF_SETUP;
        end
      end
      S_OFF_SETUP:  state_d = S_OFF_STB;
      S_OFF_STB:    state_d = on_q ? S_INCR_SETUP : S_IDLE;
      S_INCR_SETUP: state_d = S_INCR_STB;
      S_INCR_STB:   state_d = S_ON_SETUP;
      S_ON_SETUP:   state_d = S_ON_STB;
      S_ON_STB:     state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    if (age_step) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == v_d) begin
          ages_d[i] = '0;
        end else if (busy_q[i] && ages_q[i] != AGE_MAX) begin
          ages_d[i] = ages_q[i] + AGE_W'(1);
        end
      end
    end

    // Bus outputs are decoded from the next state so they leave the flops glitch-free.
    window = BASE_ADDR + 16'(v_d) * 16'(CHAN_STRIDE);
    addr_d = addr_q;
    data_d = data_q;
    case (state_d)
      S_OFF_SETUP: begin
        addr_d = window + REG_GATE;
        data_d = 8'h00;
      end
      S_INCR_SETUP: begin
        addr_d = window + REG_INCR;
        data_d = incr_q;
      end
      S_ON_SETUP: begin
        addr_d = window + REG_GATE;
        data_d = 8'h01;
      end
      default: ;
    endcase

    bus_clk_d  = is_strobe(state_d);
    ev_ready_d = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      ev_ready_q <= 1'b0;
      key_q      <= '0;
      on_q       <= 1'b0;
      incr_q     <= '0;
      v_q        <= '0;
      busy_q     <= '0;
      // NOTE: the key and age tables are small register files and must read as zero after reset.
      keys_q     <= '0;
      ages_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      bus_clk_q  <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ev_ready_q <= ev_ready_d;
      key_q      <= key_d;
      on_q       <= on_d;
      incr_q     <= incr_d;
      v_q        <= v_d;
      busy_q     <= busy_d;
      keys_q     <= keys_d;
      ages_q     <= ages_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      bus_clk_q  <= bus_clk_d;
      dropped_q  <= dropped_d;
    end
  end

  assign EvReady      = ev_ready_q;
  assign BusAddress   = addr_q;
  assign BusData      = data_q;
  assign BusReadWrite = 1'b1;
  assign BusClock     = bus_clk_q;
  assign VoiceBusy    = busy_q;
  assign Dropped      = dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random
// note traffic compared against an array-based model of the allocation rules.
module tb_voice_allocator;

  localparam int NV     = 4;
  localparam int STRIDE = 8;
`ifdef VOICE_ALLOC_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic          Clock, Reset, EvValid, EvReady, EvNoteOn;
  logic [6:0]    EvKey;
  logic [7:0]    EvIncr;
  logic [15:0]   BusAddress;
  logic [7:0]    BusData;
  logic          BusReadWrite, BusClock, Dropped;
  logic [NV-1:0] VoiceBusy;

  voice_allocator dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .EvValid      (EvValid),
    .EvReady      (EvReady),
    .EvNoteOn     (EvNoteOn),
    .EvKey        (EvKey),
    .EvIncr       (EvIncr),
    .BusAddress   (BusAddress),
    .BusData      (BusData),
    .BusReadWrite (BusReadWrite),
    .BusClock     (BusClock),
    .VoiceBusy    (VoiceBusy),
    .Dropped      (Dropped)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_busy [NV];
  int          m_key  [NV];
  int          m_age  [NV];
  logic [15:0] m_last_addr;
  logic [7:0]  m_last_data;

  // Observations from the most recent event.
  logic [15:0] got_a[$];
  logic [7:0]  got_d[$];
  int          ready_cyc, drops, drop_cyc;

  function automatic logic [NV-1:0] model_busy();
    logic [NV-1:0] b;
    for (int i = 0; i < NV; i++) b[i] = m_busy[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_busy[i] = 1'b0;
      m_key[i]  = 0;
      m_age[i]  = 0;
    end
    m_last_addr = 16'h0000;
    m_last_data = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (BusClock !== 1'b0 || EvReady !== 1'b0 || Dropped !== 1'b0 || BusReadWrite !== 1'b1 ||
        BusAddress !== 16'h0000 || BusData !== 8'h00 || VoiceBusy !== '0)
      begin
        errors++;
        $display("FAIL %s got clk=%b rdy=%b drop=%b rw=%b addr=%h data=%h busy=%b want 0 0 0 1 0000 00 0000",
                 tag, BusClock, EvReady, Dropped, BusReadWrite, BusAddress, BusData, VoiceBusy);
      end
  endtask

  task automatic do_reset();
    EvValid = 1'b0;
    Reset   = 1'b0;
    model_reset();
    repeat (2) @(negedge Clock);
    check_reset_outputs("reset_hold");
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    checks++;
    if (EvReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 1", EvReady);
    end
  endtask

  // Drive one event, observe it to completion, and compare against the model.
  task automatic send(input bit on, input logic [6:0] k, input logic [7:0] inc, input string tag);
    logic [15:0] ea[$];
    logic [7:0]  ed[$];
    int          exp_cyc, exp_drop, v, base;

    for (int n = 0; n < 20 && EvReady !== 1'b1; n++) @(negedge Clock);
    checks++;
    if (EvReady !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before got %b want 1", tag, EvReady);
    end

    EvValid = 1'b1; EvNoteOn = on; EvKey = k; EvIncr = inc;
    @(posedge Clock);
    #1;
    // Scramble the inputs: the event must already be captured.
    EvValid  = 1'b0;
    EvNoteOn = 1'($urandom);
    EvKey    = 7'($urandom);
    EvIncr   = 8'($urandom);

    got_a.delete(); got_d.delete();
    ready_cyc = 0; drops = 0; drop_cyc = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clock);
      if (BusClock === 1'b1) begin
        got_a.push_back(BusAddress);
        got_d.push_back(BusData);
      end
      if (Dropped === 1'b1) begin
        drops++;
        drop_cyc = n;
      end
      if (EvReady === 1'b1) begin
        ready_cyc = n;
        break;
      end
    end

    // Model: apply the allocation rules to the arrays.
    exp_drop = 0;
    v        = -1;
    if (on) begin
      for (int i = 0; i < NV && v < 0; i++) if (m_busy[i] && m_key[i] == int'(k)) v = i;
      if (v >= 0) exp_cyc = 8;
      else begin
        for (int i = 0; i < NV && v < 0; i++) if (!m_busy[i]) v = i;
        if (v >= 0) exp_cyc = 6;
        else if (STEAL) begin
          v = 0;
          for (int i = 1; i < NV; i++) if (m_age[i] > m_age[v]) v = i;
          exp_cyc = 8;
        end else begin
          exp_cyc  = 2;
          exp_drop = 1;
        end
      end
      if (!exp_drop) begin
        base = v * STRIDE;
        if (exp_cyc == 8) begin ea.push_back(16'(base)); ed.push_back(8'h00); end
        ea.push_back(16'(base + 1)); ed.push_back(inc);
        ea.push_back(16'(base));     ed.push_back(8'h01);
        for (int i = 0; i < NV; i++)
          if (i == v) m_age[i] = 0;
          else if (m_busy[i] && m_age[i] < 255) m_age[i]++;
        m_busy[v] = 1'b1;
        m_key[v]  = int'(k);
      end
    end else begin
      for (int i = 0; i < NV && v < 0; i++) if (m_busy[i] && m_key[i] == int'(k)) v = i;
      if (v >= 0) begin
        exp_cyc = 4;
        ea.push_back(16'(v * STRIDE)); ed.push_back(8'h00);
        m_busy[v] = 1'b0;
      end else exp_cyc = 2;
    end
    if (ea.size() > 0) begin
      m_last_addr = ea[ea.size()-1];
      m_last_data = ed[ed.size()-1];
    end

    checks++;
    if (ready_cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s ready_cycle got %0d want %0d", tag, ready_cyc, exp_cyc);
    end
    checks++;
    if (got_a.size() != ea.size()) begin
      errors++;
      $display("FAIL %s write_count got %0d want %0d", tag, got_a.size(), ea.size());
    end
    for (int i = 0; i < ea.size(); i++) begin
      checks++;
      if (i >= got_a.size() || got_a[i] !== ea[i] || got_d[i] !== ed[i]) begin
        errors++;
        if (i < got_a.size())
          $display("FAIL %s write%0d got %h/%h want %h/%h", tag, i, got_a[i], got_d[i], ea[i], ed[i]);
        else
          $display("FAIL %s write%0d got none want %h/%h", tag, i, ea[i], ed[i]);
      end
    end
    checks++;
    if (drops != exp_drop || (exp_drop == 1 && drop_cyc != 1)) begin
      errors++;
      $display("FAIL %s dropped got %0d pulses (cycle %0d) want %0d at cycle 1", tag, drops, drop_cyc, exp_drop);
    end
    checks++;
    if (VoiceBusy !== model_busy()) begin
      errors++;
      $display("FAIL %s voice_busy got %b want %b", tag, VoiceBusy, model_busy());
    end
    checks++;
    if (BusAddress !== m_last_addr || BusData !== m_last_data || BusReadWrite !== 1'b1) begin
      errors++;
      $display("FAIL %s bus_hold got %h/%h rw=%b want %h/%h rw=1", tag, BusAddress, BusData,
               BusReadWrite, m_last_addr, m_last_data);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; EvValid = 1'b0; EvNoteOn = 1'b0; EvKey = '0; EvIncr = '0;
    #3;
    do_reset();
  endtask

  task automatic test_first_note();
    do_reset();
    send(1'b1, 7'd60, 8'h20, "first_on");
    checks++;
    if (got_a.size() != 2 || got_a[0] !== 16'h0001 || got_d[0] !== 8'h20 ||
        got_a[1] !== 16'h0000 || got_d[1] !== 8'h01 || VoiceBusy !== 4'b0001 || ready_cyc != 6)
      begin
        errors++;
        $display("FAIL first_on_literal got n=%0d busy=%b ready=%0d want 2 writes busy=0001 ready=6",
                 got_a.size(), VoiceBusy, ready_cyc);
      end
  endtask

  task automatic test_note_off();
    send(1'b1, 7'd62, 8'h11, "on62");
    send(1'b1, 7'd64, 8'h12, "on64");
    send(1'b1, 7'd65, 8'h13, "on65");
    send(1'b0, 7'd62, 8'h00, "off62");
    checks++;
    if (got_a.size() != 1 || got_a[0] !== 16'h0008 || got_d[0] !== 8'h00 || VoiceBusy !== 4'b1101) begin
      errors++;
      $display("FAIL off62_literal got n=%0d busy=%b want write 0008/00 busy=1101", got_a.size(), VoiceBusy);
    end
    send(1'b0, 7'd70, 8'h00, "off70_unplayed");
    checks++;
    if (got_a.size() != 0 || ready_cyc != 2) begin
      errors++;
      $display("FAIL off70_literal got n=%0d ready=%0d want 0 writes ready=2", got_a.size(), ready_cyc);
    end
  endtask

  task automatic test_full();
    do_reset();
    send(1'b1, 7'd60, 8'h21, "full_on60");
    send(1'b1, 7'd62, 8'h22, "full_on62");
    send(1'b1, 7'd64, 8'h23, "full_on64");
    send(1'b1, 7'd65, 8'h24, "full_on65");
    send(1'b1, 7'd67, 8'h25, "full_on67");
    checks++;
    if (STEAL ? (got_a.size() != 3 || got_a[0] !== 16'h0000 || got_a[1] !== 16'h0001)
              : (got_a.size() != 0 || drops != 1 || VoiceBusy !== 4'b1111)) begin
      errors++;
      $display("FAIL full_literal got n=%0d drops=%0d busy=%b", got_a.size(), drops, VoiceBusy);
    end
    send(1'b1, 7'd64, 8'h26, "retrigger64");
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    EvValid = 1'b1; EvNoteOn = 1'b1; EvKey = 7'd61; EvIncr = 8'h55;
    @(posedge Clock);
    #1;
    EvValid = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if (BusClock !== 1'b1 || BusAddress !== 16'h0001 || BusData !== 8'h55) begin
      errors++;
      $display("FAIL incr_stb got clk=%b %h/%h want 1 0001/55", BusClock, BusAddress, BusData);
    end
    #2 Reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_write");
    model_reset();
    @(posedge Clock);
    #1;
    check_reset_outputs("reset_mid_write_held");
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    checks++;
    if (EvReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_mid_reset got %b want 1", EvReady);
    end
    send(1'b1, 7'd61, 8'h33, "after_mid_reset");
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 150; n++)
      send($urandom_range(0, 3) != 0, 7'($urandom_range(60, 67)), 8'($urandom), "random");
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_note_off();
    test_full();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
